mux8_rr_sched: RTL and testbench



---
 rtl/mux8_rr_sched.sv | 102 ++++++++++
 tb/tb_mux8_rr_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin owner scheduler for a shared 8:1 mux; optional MUX8_RR_MASK_EN adds a request mask port
module mux8_rr_sched #(
    parameter int QUANTUM = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    req,
    input  logic          done,
`ifdef MUX8_RR_MASK_EN
    input  logic [7:0]    mask,
`endif
    output logic [2:0]    sl,
    output logic [7:0]    gnt,
    output logic          vld,
    output logic [CW-1:0] cnt
);
    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n, sl_n, base, win, idx;
    logic [7:0]    eff, gnt_n;
    logic          vld_n, any, rel;
    logic [CW-1:0] cnt_n;

`ifdef MUX8_RR_MASK_EN
    assign eff = req & ~mask;
`else
    assign eff = req;
`endif

    // a releasing owner searches from its own index, which is exactly the ptr it is about to store
    assign base = (state == OWN) ? sl : ptr;
    assign rel  = done | ~eff[sl] | (cnt == LAST);

    // rotating priority search: scanning downward lets the nearest index after base win
    always_comb begin
        any = 1'b0;
        win = 3'd0;
        idx = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            idx = base + 3'(k);
            if (eff[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sl_n    = sl;
        gnt_n   = gnt;
        vld_n   = vld;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (any) begin
                state_n = OWN;
                sl_n    = win;
                gnt_n   = 8'b1 << win;
                vld_n   = 1'b1;
                cnt_n   = '0;
            end
        end else if (!rel) begin
            cnt_n = cnt + CW'(1);
        end else begin
            ptr_n = sl;
            cnt_n = '0;
            if (any) begin
                sl_n  = win;
                gnt_n = 8'b1 << win;
            end else begin
                state_n = IDLE;
                gnt_n   = '0;
                vld_n   = 1'b0;
            end
        end
    end

    // registered state and outputs with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd7;
            sl    <= 3'd0;
            gnt   <= '0;
            vld   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sl    <= sl_n;
            gnt   <= gnt_n;
            vld   <= vld_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: randomized and directed checks of mux8_rr_sched against a behavioural model
module tb_mux8_rr_sched;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] mask = '0;
    logic [2:0] sl;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] cnt;

    int errs = 0;
    int checks = 0;

    // model: owner index or -1 when idle
    int m_own, m_cnt, m_ptr, m_sl;

    mux8_rr_sched #(.QUANTUM(Q), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
`ifdef MUX8_RR_MASK_EN
        .mask(mask),
`endif
        .sl(sl), .gnt(gnt), .vld(vld), .cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] eff_req();
`ifdef MUX8_RR_MASK_EN
        return req & ~mask;
`else
        return req;
`endif
    endfunction

    function automatic int search(input int from, input logic [7:0] r);
        for (int k = 1; k <= 8; k++)
            if (r[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_ptr = 7; m_sl = 0;
    endtask

    task automatic model_next();
        logic [7:0] r;
        int w;
        r = eff_req();
        if (m_own < 0) begin
            w = search(m_ptr, r);
            if (w >= 0) begin m_own = w; m_sl = w; m_cnt = 0; end
        end else if (!(done || !r[m_own] || m_cnt == Q - 1)) begin
            m_cnt++;
        end else begin
            m_ptr = m_own;
            w = search(m_ptr, r);
            if (w >= 0) begin m_own = w; m_sl = w; m_cnt = 0; end
            else m_own = -1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] eg;
        eg = (m_own >= 0) ? (8'b1 << m_sl) : 8'h00;
        chk({tag, ".vld"}, 32'(vld), 32'(m_own >= 0));
        chk({tag, ".sl"}, 32'(sl), 32'(m_sl));
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        if (m_own >= 0) chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
    endtask

    task automatic step(input string tag);
        model_next();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("reset");
        chk("reset.cnt0", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // single requester: regrant every quantum
        req = 8'h08;
        step("single");
        chk("single.first_sl", 32'(sl), 32'd3);
        for (int i = 0; i < 10; i++) step("single");

        // full rotation
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 36; i++) step("rot");

        // early release
        do_reset();
        req = 8'h21;
        step("early");
        step("early");
        chk("early.cnt1", 32'(cnt), 32'd1);
        done = 1'b1;
        step("early");
        done = 1'b0;
        chk("early.sl5", 32'(sl), 32'd5);
        for (int i = 0; i < 6; i++) step("early");

        // drop to idle
        do_reset();
        req = 8'h04;
        step("drop");
        step("drop");
        step("drop");
        chk("drop.cnt2", 32'(cnt), 32'd2);
        req = 8'h00;
        step("drop");
        chk("drop.idle", 32'(vld), 32'd0);
        req = 8'h02;
        step("drop");
        chk("drop.sl1", 32'(sl), 32'd1);

        // async reset mid-grant
        do_reset();
        req = 8'h40;
        step("async");
        step("async");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async.vld", 32'(vld), 32'd0);
        chk("async.gnt", 32'(gnt), 32'd0);
        chk("async.cnt", 32'(cnt), 32'd0);
        req = 8'hC1;
        @(negedge clk);
        rst_n = 1'b1;
        step("async");
        chk("async.sl0", 32'(sl), 32'd0);

`ifdef MUX8_RR_MASK_EN
        // mask restricts rotation; masking the owner releases it
        do_reset();
        req = 8'hFF;
        mask = 8'h0F;
        for (int i = 0; i < 18; i++) step("mask");
        mask = 8'h0F | (8'b1 << sl);
        step("mask.own");
        mask = 8'h00;
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req  = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 5) == 0);
`ifdef MUX8_RR_MASK_EN
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
`endif
            step("rand");
        end
        done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
